// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the Huffman tree builder front end.
package t05_huff_pkg;
  localparam int unsigned HIST_W   = 32;
  localparam int unsigned SUM_W    = 64;
  localparam int unsigned MAX_SN   = 128;
  localparam int unsigned SN_IDX_W = 7;
  localparam int unsigned NODE_W   = 9;

  typedef logic [NODE_W-1:0] node_t;

  localparam node_t NODE_NULL = 9'b1_1000_0000;

  typedef enum logic [2:0] {
    FLV_IDLE,
    FLV_SCAN_LEAF,
    FLV_SCAN_SUM,
    FLV_DRAIN,
    FLV_DONE
  } flv_state_t;

  function automatic node_t leaf_node(input logic [7:0] ch);
    return {1'b0, ch};
  endfunction

  function automatic node_t sum_node(input logic [SN_IDX_W-1:0] idx);
    return {2'b10, idx};
  endfunction
endpackage

// File: rtl/t05_min2_tracker.sv
// Registered two-minimum compare/insert cell; strict less-than keeps the earlier node on ties.
module t05_min2_tracker
  import t05_huff_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             cand_vld_i,
  input  node_t            cand_node_i,
  input  logic [SUM_W-1:0] cand_val_i,
  output node_t            m1_node_o,
  output logic [SUM_W-1:0] m1_val_o,
  output node_t            m2_node_o,
  output logic [SUM_W-1:0] m2_val_o
);
  node_t            m1_node_q, m1_node_d, m2_node_q, m2_node_d;
  logic [SUM_W-1:0] m1_val_q, m1_val_d, m2_val_q, m2_val_d;

  always_comb begin
    m1_node_d = m1_node_q;
    m1_val_d  = m1_val_q;
    m2_node_d = m2_node_q;
    m2_val_d  = m2_val_q;
    if (clear_i) begin
      m1_node_d = NODE_NULL;
      m1_val_d  = '1;
      m2_node_d = NODE_NULL;
      m2_val_d  = '1;
    end else if (cand_vld_i) begin
      if (cand_val_i < m1_val_q) begin
        m2_node_d = m1_node_q;
        m2_val_d  = m1_val_q;
        m1_node_d = cand_node_i;
        m1_val_d  = cand_val_i;
      end else if (cand_val_i < m2_val_q) begin
        m2_node_d = cand_node_i;
        m2_val_d  = cand_val_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_node_q <= NODE_NULL;
      m1_val_q  <= '1;
      m2_node_q <= NODE_NULL;
      m2_val_q  <= '1;
    end else begin
      m1_node_q <= m1_node_d;
      m1_val_q  <= m1_val_d;
      m2_node_q <= m2_node_d;
      m2_val_q  <= m2_val_d;
    end
  end

  assign m1_node_o = m1_node_q;
  assign m1_val_o  = m1_val_q;
  assign m2_node_o = m2_node_q;
  assign m2_val_o  = m2_val_q;
endmodule

// File: rtl/t05_find_least.sv
// Finds the two least-frequent unconsumed leaf/sum nodes per pass.
// Optional T05_FLV_CANDCOUNT_EN adds cand_count (candidates seen in the last pass).
module t05_find_least
  import t05_huff_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                start,
  input  logic [SN_IDX_W-1:0] sn_count,
  output logic [7:0]          hist_addr,
  input  logic [HIST_W-1:0]   hist_data,
  output logic [SN_IDX_W-1:0] sn_addr,
  input  logic [SUM_W-1:0]    sn_data,
  output logic                rd_en,
  output node_t               least1,
  output node_t               least2,
  output logic [SUM_W-1:0]    sum,
  output logic                busy,
  output logic                done
`ifdef T05_FLV_CANDCOUNT_EN
  ,
  output logic [8:0]          cand_count
`endif
);
  flv_state_t          state_q;
  logic [SN_IDX_W-1:0] s_q, sn_addr_q;
  logic [7:0]          cnt_q, hist_addr_q, tag_idx_q;
  logic                drain_q, rd_en_q, rd_sum_q, tag_vld_q, tag_sum_q;
  logic                busy_q, done_q;
  logic [255:0]        leaf_used_q;
  logic [MAX_SN-1:0]   sn_used_q;
  node_t               least1_q, least2_q;
  logic [SUM_W-1:0]    sum_q;

  logic                start_ok, cand_vld;
  node_t               cand_node, m1_node, m2_node;
  logic [SUM_W-1:0]    cand_val, m1_val, m2_val;

  assign start_ok = (state_q == FLV_IDLE) && start && !init;

  // Qualify the word returned for the address issued one cycle earlier.
  always_comb begin
    cand_vld  = 1'b0;
    cand_node = NODE_NULL;
    cand_val  = '0;
    if (tag_vld_q) begin
      if (tag_sum_q) begin
        cand_vld  = !sn_used_q[tag_idx_q[SN_IDX_W-1:0]];
        cand_node = sum_node(tag_idx_q[SN_IDX_W-1:0]);
        cand_val  = sn_data;
      end else begin
        cand_vld  = (hist_data != '0) && !leaf_used_q[tag_idx_q];
        cand_node = leaf_node(tag_idx_q);
        cand_val  = SUM_W'(hist_data);
      end
    end
  end

  t05_min2_tracker u_min2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_ok),
    .cand_vld_i (cand_vld),
    .cand_node_i(cand_node),
    .cand_val_i (cand_val),
    .m1_node_o  (m1_node),
    .m1_val_o   (m1_val),
    .m2_node_o  (m2_node),
    .m2_val_o   (m2_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FLV_IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      hist_addr_q <= '0;
      sn_addr_q   <= '0;
      rd_en_q     <= 1'b0;
      rd_sum_q    <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_sum_q   <= 1'b0;
      tag_idx_q   <= '0;
      leaf_used_q <= '0;
      sn_used_q   <= '0;
      least1_q    <= NODE_NULL;
      least2_q    <= NODE_NULL;
      sum_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      tag_vld_q <= rd_en_q;
      tag_sum_q <= rd_sum_q;
      tag_idx_q <= rd_sum_q ? {1'b0, sn_addr_q} : hist_addr_q;
      case (state_q)
        FLV_IDLE: begin
          if (init) begin
            leaf_used_q <= '0;
            sn_used_q   <= '0;
          end else if (start) begin
            s_q     <= sn_count;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FLV_SCAN_LEAF;
          end
        end
        FLV_SCAN_LEAF: begin
          hist_addr_q <= cnt_q;
          rd_en_q     <= 1'b1;
          rd_sum_q    <= 1'b0;
          cnt_q       <= 8'(cnt_q + 8'd1);
          drain_q     <= 1'b0;
          if (cnt_q == 8'hFF) begin
            state_q <= (s_q == '0) ? FLV_DRAIN : FLV_SCAN_SUM;
          end
        end
        FLV_SCAN_SUM: begin
          sn_addr_q <= cnt_q[SN_IDX_W-1:0];
          rd_en_q   <= 1'b1;
          rd_sum_q  <= 1'b1;
          cnt_q     <= 8'(cnt_q + 8'd1);
          if (cnt_q[SN_IDX_W-1:0] == SN_IDX_W'(s_q - 7'd1)) state_q <= FLV_DRAIN;
        end
        // Two cycles cover the read latency plus the final compare.
        FLV_DRAIN: begin
          rd_en_q <= 1'b0;
          drain_q <= 1'b1;
          if (drain_q) state_q <= FLV_DONE;
        end
        FLV_DONE: begin
          if (m1_node == NODE_NULL) begin
            least1_q <= NODE_NULL;
            least2_q <= NODE_NULL;
            sum_q    <= '0;
          end else begin
            least1_q <= m1_node;
            if (!m1_node[8]) leaf_used_q[m1_node[7:0]] <= 1'b1;
            else             sn_used_q[m1_node[SN_IDX_W-1:0]] <= 1'b1;
            if (m2_node == NODE_NULL) begin
              least2_q <= NODE_NULL;
              sum_q    <= m1_val;
            end else begin
              least2_q <= m2_node;
              sum_q    <= m1_val + m2_val;
              if (!m2_node[8]) leaf_used_q[m2_node[7:0]] <= 1'b1;
              else             sn_used_q[m2_node[SN_IDX_W-1:0]] <= 1'b1;
            end
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= FLV_IDLE;
        end
        default: state_q <= FLV_IDLE;
      endcase
    end
  end

`ifdef T05_FLV_CANDCOUNT_EN
  logic [8:0] cc_run_q, cand_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_run_q     <= '0;
      cand_count_q <= '0;
    end else begin
      if (start_ok)      cc_run_q <= '0;
      else if (cand_vld) cc_run_q <= 9'(cc_run_q + 9'd1);
      if (state_q == FLV_DONE) cand_count_q <= cc_run_q;
    end
  end

  assign cand_count = cand_count_q;
`endif

  assign hist_addr = hist_addr_q;
  assign sn_addr   = sn_addr_q;
  assign rd_en     = rd_en_q;
  assign least1    = least1_q;
  assign least2    = least2_q;
  assign sum       = sum_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_t05_find_least.sv
// Self-checking bench for t05_find_least with histogram/sum-node memories and a result scoreboard.
module tb_t05_find_least;
  localparam logic [8:0] NUL = 9'b1_1000_0000;

  typedef struct {
    logic [8:0]  l1;
    logic [8:0]  l2;
    logic [63:0] sm;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  sn_count = '0;
  logic [7:0]  hist_addr;
  logic [31:0] hist_data = '0;
  logic [6:0]  sn_addr;
  logic [63:0] sn_data = '0;
  logic        rd_en, busy, done;
  logic [8:0]  least1, least2;
  logic [63:0] sum;
`ifdef T05_FLV_CANDCOUNT_EN
  logic [8:0]  cand_count;
`endif

  logic [31:0] hist_mem [0:255];
  logic [63:0] sn_mem   [0:127];
  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;

  t05_find_least dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (init),
    .start    (start),
    .sn_count (sn_count),
    .hist_addr(hist_addr),
    .hist_data(hist_data),
    .sn_addr  (sn_addr),
    .sn_data  (sn_data),
    .rd_en    (rd_en),
    .least1   (least1),
    .least2   (least2),
    .sum      (sum),
    .busy     (busy),
    .done     (done)
`ifdef T05_FLV_CANDCOUNT_EN
    ,
    .cand_count(cand_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    hist_data <= hist_mem[hist_addr];
    sn_data   <= sn_mem[sn_addr];
  end

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) hist_mem[i] = '0;
    for (int i = 0; i < 128; i++) sn_mem[i] = '0;
  endtask

  task automatic pulse_init();
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
  endtask

  // Pulses start, scrambles sn_count afterwards, waits (bounded) for done.
  task automatic run_pass(input logic [6:0] s, output int lat, output logic busy_seen);
    @(negedge clk); sn_count = s; start = 1'b1;
    @(negedge clk); start = 1'b0; sn_count = 7'h55;
    busy_seen = busy;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (least1 !== NUL) begin errors++; $display("FAIL reset least1: got %h expected %h", least1, NUL); end
    checks++; if (least2 !== NUL) begin errors++; $display("FAIL reset least2: got %h expected %h", least2, NUL); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL reset sum: got %h expected 0", sum); end
    checks++; if ({busy, done, rd_en} !== 3'b000) begin errors++; $display("FAIL reset busy/done/rd_en: got %b expected 000", {busy, done, rd_en}); end
    checks++; if ({hist_addr, sn_addr} !== 15'd0) begin errors++; $display("FAIL reset addrs: got %h/%h expected 0/0", hist_addr, sn_addr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    logic bz;
    int   dcnt;
    clear_mems();
    hist_mem[8'h61] = 32'd5;
    hist_mem[8'h62] = 32'd2;
    hist_mem[8'h63] = 32'd9;
    pulse_init();
    sb_q.push_back('{9'h062, 9'h061, 64'd7, 259});
    sb_q.push_back('{9'h063, NUL, 64'd9, 259});
    sb_q.push_back('{NUL, NUL, 64'd0, 259});
    for (int p = 0; p < 3; p++) begin
      run_pass(7'd0, lat, bz);
      e = sb_q.pop_front();
      checks++; if (bz !== 1'b1) begin errors++; $display("FAIL basic busy_rise pass%0d: got %b expected 1", p, bz); end
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL basic latency pass%0d: got %0d expected %0d", p, lat, e.lat); end
      checks++; if (least1 !== e.l1) begin errors++; $display("FAIL basic least1 pass%0d: got %h expected %h", p, least1, e.l1); end
      checks++; if (least2 !== e.l2) begin errors++; $display("FAIL basic least2 pass%0d: got %h expected %h", p, least2, e.l2); end
      checks++; if (sum !== e.sm) begin errors++; $display("FAIL basic sum pass%0d: got %h expected %h", p, sum, e.sm); end
`ifdef T05_FLV_CANDCOUNT_EN
      if (p == 0) begin
        checks++; if (cand_count !== 9'd3) begin errors++; $display("FAIL basic cand_count: got %0d expected 3", cand_count); end
      end
`endif
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic done_pulse pass%0d: got %b expected 00", p, {busy, done}); end
    end
    // init together with start: init wins, no pass runs.
    @(negedge clk); init = 1'b1; start = 1'b1;
    @(negedge clk); init = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_start busy: got %b expected 0", busy); end
    dcnt = 0;
    repeat (300) begin @(negedge clk); if (done) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL init_start spurious_done: got %0d expected 0", dcnt); end
    sb_q.push_back('{9'h062, 9'h061, 64'd7, 259});
    run_pass(7'd0, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL reinit latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2} !== {e.l1, e.l2}) begin errors++; $display("FAIL reinit nodes: got %h/%h expected %h/%h", least1, least2, e.l1, e.l2); end
    checks++; if (sum !== e.sm) begin errors++; $display("FAIL reinit sum: got %h expected %h", sum, e.sm); end
  endtask

  task automatic test_tie();
    exp_t e;
    int   lat;
    logic bz;
    clear_mems();
    hist_mem[8'h78] = 32'd3;
    hist_mem[8'h79] = 32'd3;
    sn_mem[0] = 64'd3;
    pulse_init();
    sb_q.push_back('{9'h078, 9'h079, 64'd6, 260});
    run_pass(7'd1, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL tie latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2} !== {e.l1, e.l2}) begin errors++; $display("FAIL tie nodes: got %h/%h expected %h/%h", least1, least2, e.l1, e.l2); end
    checks++; if (sum !== e.sm) begin errors++; $display("FAIL tie sum: got %h expected %h", sum, e.sm); end
  endtask

  task automatic test_reset_midpass();
    exp_t e;
    int   lat;
    int   w;
    logic bz;
    @(negedge clk); sn_count = 7'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (hist_addr != 8'd100 && w < 400) begin @(negedge clk); w++; end
    checks++; if (w >= 400) begin errors++; $display("FAIL midpass addr100_timeout: got %0d cycles expected <400", w); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, rd_en} !== 3'b000) begin errors++; $display("FAIL midpass busy/done/rd_en: got %b expected 000", {busy, done, rd_en}); end
    checks++; if ({least1, least2} !== {NUL, NUL}) begin errors++; $display("FAIL midpass nodes: got %h/%h expected NULL/NULL", least1, least2); end
    checks++; if (sum !== 64'd0) begin errors++; $display("FAIL midpass sum: got %h expected 0", sum); end
    @(negedge clk); rst_n = 1'b1;
    sb_q.push_back('{9'h078, 9'h079, 64'd6, 260});
    run_pass(7'd1, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL postreset latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2, sum} !== {e.l1, e.l2, e.sm}) begin errors++; $display("FAIL postreset result: got %h/%h/%h expected %h/%h/%h", least1, least2, sum, e.l1, e.l2, e.sm); end
  endtask

  task automatic test_preconsumed();
    exp_t e;
    int   lat;
    logic bz;
    clear_mems();
    pulse_init();
    // Zero-valued sum nodes still count and are consumed here.
    sb_q.push_back('{9'h100, 9'h101, 64'd0, 261});
    run_pass(7'd2, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL zero_sn latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2, sum} !== {e.l1, e.l2, e.sm}) begin errors++; $display("FAIL zero_sn result: got %h/%h/%h expected %h/%h/%h", least1, least2, sum, e.l1, e.l2, e.sm); end
    sn_mem[2] = 64'd1;
    hist_mem[8'h71] = 32'd4;
    sb_q.push_back('{9'h102, 9'h071, 64'd5, 262});
    run_pass(7'd3, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL preconsumed latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2, sum} !== {e.l1, e.l2, e.sm}) begin errors++; $display("FAIL preconsumed result: got %h/%h/%h expected %h/%h/%h", least1, least2, sum, e.l1, e.l2, e.sm); end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   lat;
    logic bz;
    clear_mems();
    sn_mem[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    sn_mem[1] = 64'hFFFF_FFFF_FFFF_FFFD;
    pulse_init();
    sb_q.push_back('{9'h101, 9'h100, 64'hFFFF_FFFF_FFFF_FFFB, 261});
    run_pass(7'd2, lat, bz);
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL wrap latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2} !== {e.l1, e.l2}) begin errors++; $display("FAIL wrap nodes: got %h/%h expected %h/%h", least1, least2, e.l1, e.l2); end
    checks++; if (sum !== e.sm) begin errors++; $display("FAIL wrap sum: got %h expected %h", sum, e.sm); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    int   dcnt;
    pulse_init();
    sb_q.push_back('{9'h101, 9'h100, 64'hFFFF_FFFF_FFFF_FFFB, 261});
    @(negedge clk); sn_count = 7'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (lat < 2000) begin
      @(posedge clk); lat++;
      @(negedge clk);
      start = (lat == 50);
      if (done) break;
    end
    start = 1'b0;
    e = sb_q.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b latency: got %0d expected %0d", lat, e.lat); end
    checks++; if ({least1, least2, sum} !== {e.l1, e.l2, e.sm}) begin errors++; $display("FAIL b2b result: got %h/%h/%h expected %h/%h/%h", least1, least2, sum, e.l1, e.l2, e.sm); end
    dcnt = 0;
    repeat (300) begin @(negedge clk); if (done || busy) dcnt++; end
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL b2b ignored_start: got %0d active cycles expected 0", dcnt); end
  endtask

  initial begin
    clear_mems();
    test_reset();
    test_basic();
    test_tie();
    test_reset_midpass();
    test_preconsumed();
    test_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
